// File: rtl/vliw_pkg.sv
// Shared VLIW front-end types: dispatch FSM states, instruction word width and
// the bundle layout used between fetch/dispatch and the functional-unit array.
package vliw_pkg;

  localparam int unsigned INSN_W         = 32;
  localparam int unsigned PC_W           = 64;
  localparam int unsigned NUM_FU_DEFAULT = 4;

  typedef enum logic [2:0] {
    REQ,
    WAIT_RSP,
    WAIT_FU,
    ISSUE,
    SETTLE
  } dispatch_state_t;

  // Slot i feeds functional unit i.
  typedef logic [NUM_FU_DEFAULT-1:0][INSN_W-1:0] bundle_t;

  // Clears the low lsb_w bits so a redirect target lands on a bundle boundary.
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr,
                                               input int unsigned     lsb_w);
    return (addr >> lsb_w) << lsb_w;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Bundle program counter: reset beats redirect, redirect beats increment.
// Redirect targets are forced onto a bundle boundary; increment wraps mod 2^64.
module fetch_pc
  import vliw_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     BUNDLE_B = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_addr,
  input  logic            incr,
  output logic [PC_W-1:0] pc
);

  localparam int unsigned ALIGN_W = $clog2(BUNDLE_B);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_addr, ALIGN_W);
    end else if (incr) begin
      pc_d = pc_q + PC_W'(BUNDLE_B);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/bundle_dispatch.sv
// Fetch/dispatch stage: fetches one bundle per request, waits for an idle FU
// array, then broadcasts every slot to its FU with a one-cycle issue strobe.
module bundle_dispatch
  import vliw_pkg::*;
#(
  parameter int unsigned NUM_FU   = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     memReqValid,
  input  logic                     memReqReady,
  output logic [63:0]              memAddr,
  input  logic                     memRespValid,
  input  logic [INSN_W*NUM_FU-1:0] memRespData,
  input  logic [NUM_FU-1:0]        fuWorking,
  input  logic [NUM_FU-1:0]        fuStalling,
  output logic [INSN_W*NUM_FU-1:0] instruction,
  output logic [63:0]              bundleAddr,
  output logic [NUM_FU-1:0]        instructionReady,
  input  logic                     redirectValid,
  input  logic [63:0]              redirectAddr,
  output logic                     fetchBusy
);

  localparam int unsigned BUNDLE_B = NUM_FU * 4;
  localparam int unsigned BUNDLE_W = NUM_FU * INSN_W;

  dispatch_state_t     state_q, state_d;
  logic                discard_q, discard_d;
  logic [BUNDLE_W-1:0] bundle_q, bundle_d;
  logic [BUNDLE_W-1:0] instr_q, instr_d;
  logic [63:0]         baddr_q, baddr_d;
  logic [NUM_FU-1:0]   ready_q, ready_d;
  logic                req_valid_q, req_valid_d;
  logic                busy_q, busy_d;
  logic [63:0]         pc;
  logic                incr_c;

  assign incr_c = (state_q == ISSUE);

  fetch_pc #(
    .RESET_PC (RESET_PC),
    .BUNDLE_B (BUNDLE_B)
  ) u_fetch_pc (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirectValid),
    .redirect_addr  (redirectAddr),
    .incr           (incr_c),
    .pc             (pc)
  );

  // Next state and registered outputs; redirect overrides the normal flow.
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    bundle_d  = bundle_q;
    instr_d   = instr_q;
    baddr_d   = baddr_q;
    ready_d   = '0;
    unique case (state_q)
      REQ: begin
        // An accepted request is in flight at the old pc even when redirected.
        if (req_valid_q && memReqReady) begin
          state_d = WAIT_RSP;
          if (redirectValid) discard_d = 1'b1;
        end
      end
      WAIT_RSP: begin
        if (memRespValid) begin
          if (discard_q || redirectValid) begin
            discard_d = 1'b0;
            state_d   = REQ;
          end else begin
            bundle_d = memRespData;
            state_d  = WAIT_FU;
          end
        end else if (redirectValid) begin
          discard_d = 1'b1;
        end
      end
      WAIT_FU: begin
        if (redirectValid) begin
          state_d = REQ;
        end else if (fuWorking == '0 && fuStalling == '0) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        instr_d = bundle_q;
        baddr_d = pc;
        ready_d = '1;
        state_d = SETTLE;
      end
      SETTLE: begin
        // Gives the FUs a cycle to raise working before it is sampled again.
        state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    req_valid_d = (state_d == REQ);
    busy_d      = (state_d != WAIT_FU);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      discard_q   <= 1'b0;
      bundle_q    <= '0;
      instr_q     <= '0;
      baddr_q     <= '0;
      ready_q     <= '0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      bundle_q    <= bundle_d;
      instr_q     <= instr_d;
      baddr_q     <= baddr_d;
      ready_q     <= ready_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign memReqValid      = req_valid_q;
  assign memAddr          = pc;
  assign instruction      = instr_q;
  assign bundleAddr       = baddr_q;
  assign instructionReady = ready_q;
  assign fetchBusy        = busy_q;

endmodule

// File: tb/tb_bundle_dispatch.sv
// Directed bench for bundle_dispatch: a scoreboard of expected issued bundles
// is checked against every issue strobe; a second instance covers pc wrap.
module tb_bundle_dispatch;

  logic         clk;
  logic         rst;
  logic         memReqValid, memReqReady, memRespValid;
  logic [63:0]  memAddr;
  logic [127:0] memRespData;
  logic [3:0]   fuWorking, fuStalling, instructionReady;
  logic [127:0] instruction;
  logic [63:0]  bundleAddr;
  logic         redirectValid;
  logic [63:0]  redirectAddr;
  logic         fetchBusy;

  logic         w_memReqValid, w_memReqReady, w_memRespValid;
  logic [63:0]  w_memAddr;
  logic [127:0] w_memRespData;
  logic [3:0]   w_fuWorking, w_fuStalling, w_instructionReady;
  logic [127:0] w_instruction;
  logic [63:0]  w_bundleAddr;
  logic         w_redirectValid;
  logic [63:0]  w_redirectAddr;
  logic         w_fetchBusy;

  int          n_asserts = 0;
  int          n_fail    = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_e;
  int unsigned resp_delay = 0;
  logic        pend;
  int unsigned cnt;
  logic [63:0] paddr;
  logic [63:0] w_addr[2];
  int          w_cnt = 0;

  bundle_dispatch #(.NUM_FU(4), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memAddr(memAddr),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .fuWorking(fuWorking), .fuStalling(fuStalling),
    .instruction(instruction), .bundleAddr(bundleAddr),
    .instructionReady(instructionReady),
    .redirectValid(redirectValid), .redirectAddr(redirectAddr),
    .fetchBusy(fetchBusy)
  );

  bundle_dispatch #(.NUM_FU(4), .RESET_PC(64'hFFFF_FFFF_FFFF_FFF0)) dut_w (
    .clk(clk), .rst(rst),
    .memReqValid(w_memReqValid), .memReqReady(w_memReqReady), .memAddr(w_memAddr),
    .memRespValid(w_memRespValid), .memRespData(w_memRespData),
    .fuWorking(w_fuWorking), .fuStalling(w_fuStalling),
    .instruction(w_instruction), .bundleAddr(w_bundleAddr),
    .instructionReady(w_instructionReady),
    .redirectValid(w_redirectValid), .redirectAddr(w_redirectAddr),
    .fetchBusy(w_fetchBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Distinct word per slot so a slot swap or stale bundle is visible.
  function automatic logic [127:0] mk(input logic [63:0] a);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[32*i +: 32] = a[31:0] ^ {8'(i + 1), 24'h5A5A5A};
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_accept(input logic [63:0] exp_addr, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (memReqValid && memReqReady) begin
        seen = 1'b1;
        break;
      end
    end
    if (seen) check(tag, 128'(memAddr), 128'(exp_addr));
    else begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s: no request observed, expected addr %0h", tag, exp_addr);
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_asserts++;
      n_fail++;
      $error("FAIL %s: %0d expected issues never seen", tag, exp_q.size());
    end
  endtask

  // Memory model for the main instance with a programmable extra response delay.
  always @(posedge clk) begin
    if (rst) begin
      memRespValid <= 1'b0;
      pend         <= 1'b0;
      cnt          <= 0;
    end else begin
      memRespValid <= 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          memRespValid <= 1'b1;
          memRespData  <= mk(paddr);
          pend         <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (memReqValid && memReqReady) begin
        if (resp_delay == 0) begin
          memRespValid <= 1'b1;
          memRespData  <= mk(memAddr);
        end else begin
          pend  <= 1'b1;
          cnt   <= resp_delay - 1;
          paddr <= memAddr;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) w_memRespValid <= 1'b0;
    else begin
      w_memRespValid <= w_memReqValid;
      w_memRespData  <= {4{w_memAddr[31:0]}};
    end
  end

  always @(negedge clk) begin
    if (!rst && w_memReqValid && w_cnt < 2) begin
      w_addr[w_cnt] = w_memAddr;
      w_cnt++;
    end
  end

  // Scoreboard: every issue strobe must match the oldest expected bundle.
  always @(negedge clk) begin
    if (instructionReady != 4'h0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 128'(bundleAddr), 128'hFFFF_FFFF);
      end else begin
        exp_e = exp_q.pop_front();
        check("issue_ready", 128'(instructionReady), 128'(4'hF));
        check("issue_addr", 128'(bundleAddr), 128'(exp_e));
        check("issue_data", instruction, mk(exp_e));
      end
    end
  end

  initial begin
    rst             = 1'b1;
    memReqReady     = 1'b1;
    fuWorking       = 4'h0;
    fuStalling      = 4'h0;
    redirectValid   = 1'b0;
    redirectAddr    = 64'h0;
    w_memReqReady   = 1'b1;
    w_fuWorking     = 4'h0;
    w_fuStalling    = 4'h0;
    w_redirectValid = 1'b0;
    w_redirectAddr  = 64'h0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_req_valid", 128'(memReqValid), 128'(1'b0));
    check("rst_ready", 128'(instructionReady), 128'(4'h0));
    check("rst_instruction", instruction, 128'h0);
    check("rst_bundle_addr", 128'(bundleAddr), 128'h0);
    check("rst_busy", 128'(fetchBusy), 128'(1'b1));
    check("rst_mem_addr", 128'(memAddr), 128'h0);

    // Back-to-back fetches with an always-idle FU array.
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h10);
    exp_q.push_back(64'h20);
    wait_accept(64'h0, "fetch0_addr");
    wait_accept(64'h10, "fetch1_addr");
    wait_accept(64'h20, "fetch2_addr");
    wait_drain("drain_seq");
    fuWorking = 4'b0100;

    // Reset while a bundle sits in WAIT_FU: nothing issues, fetch restarts at RESET_PC.
    wait_accept(64'h30, "fetch3_addr");
    repeat (4) @(posedge clk);
    #1;
    check("wait_fu_busy", 128'(fetchBusy), 128'(1'b0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready", 128'(instructionReady), 128'(4'h0));
    check("midrst_req_valid", 128'(memReqValid), 128'(1'b0));
    resp_delay = 3;

    // FU working then stalling holds the bundle back.
    exp_q.push_back(64'h0);
    wait_accept(64'h0, "refetch_reset_pc");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_working", 128'(instructionReady), 128'(4'h0));
    end
    fuWorking  = 4'h0;
    fuStalling = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_stalling", 128'(instructionReady), 128'(4'h0));
    end
    fuStalling = 4'h0;
    @(negedge clk);
    check("release_gap", 128'(instructionReady), 128'(4'h0));
    @(negedge clk);
    check("release_issue", 128'(instructionReady), 128'(4'hF));
    check("release_bundle_addr", 128'(bundleAddr), 128'h0);

    // Redirect while the response is outstanding: response dropped, target aligned.
    exp_q.push_back(64'h1000);
    wait_accept(64'h10, "fetch_before_redirect");
    @(posedge clk);
    #1;
    check("wait_rsp_busy", 128'(fetchBusy), 128'(1'b1));
    redirectValid = 1'b1;
    redirectAddr  = 64'h1007;
    @(posedge clk);
    #1;
    redirectValid = 1'b0;
    wait_accept(64'h1000, "redirect_wait_rsp_addr");

    // Redirect in the same cycle as the response.
    exp_q.push_back(64'h2000);
    wait_accept(64'h1010, "fetch_1010");
    begin
      bit got = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (memRespValid) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        n_asserts++;
        n_fail++;
        $error("FAIL resp_wait: no memory response observed");
      end
    end
    redirectValid = 1'b1;
    redirectAddr  = 64'h2000;
    @(posedge clk);
    #1;
    redirectValid = 1'b0;
    wait_accept(64'h2000, "redirect_with_resp_addr");

    // Redirect in the same cycle the request is accepted.
    exp_q.push_back(64'h3000);
    wait_accept(64'h2010, "fetch_2010");
    redirectValid = 1'b1;
    redirectAddr  = 64'h3000;
    @(posedge clk);
    #1;
    redirectValid = 1'b0;
    wait_accept(64'h3000, "redirect_on_accept_addr");
    wait_drain("drain_final");

    check("wrap_first_fetch", 128'(w_addr[0]), 128'(64'hFFFF_FFFF_FFFF_FFF0));
    check("wrap_second_fetch", 128'(w_addr[1]), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
